// File: rtl/host_mem_responder_pkg.sv
// rtl/host_mem_responder_pkg.sv - state encodings, constants and address helpers for host_mem_responder
package host_mem_resp_pkg;

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_LAT   = 2'd1;
  localparam logic [1:0] R_READY = 2'd2;
  localparam logic [1:0] R_WAIT  = 2'd3;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_LAT   = 2'd1;
  localparam logic [1:0] W_READY = 2'd2;
  localparam logic [1:0] W_WAIT  = 2'd3;

  function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base);
    return (addr - base) >> 2;
  endfunction

  function automatic logic addr_bad(input logic [63:0] addr, input logic [63:0] base,
                                    input logic [63:0] words);
    return (addr < base) || (word_index(addr, base) >= words) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/host_mem_responder_if.sv
// rtl/host_mem_responder_if.sv - accelerator read/write beat channel between wrapper and responder
interface host_mem_responder_if #(
  parameter int DATA_WID = 32
);
  logic                read_enable;
  logic [63:0]         read_addr;
  logic [63:0]         read_size_output;
  logic                finish_read;
  logic [63:0]         read_ready;
  logic [DATA_WID-1:0] read_data;

  logic                write_enable;
  logic [63:0]         write_addr;
  logic [DATA_WID-1:0] write_data;
  logic [63:0]         write_size;
  logic                finish_write;
  logic [63:0]         write_ready;

  modport master (
    output read_enable, read_addr, read_size_output, finish_read,
    output write_enable, write_addr, write_data, write_size, finish_write,
    input  read_ready, read_data, write_ready
  );

  modport slave (
    input  read_enable, read_addr, read_size_output, finish_read,
    input  write_enable, write_addr, write_data, write_size, finish_write,
    output read_ready, read_data, write_ready
  );
endinterface

// File: rtl/host_mem_responder_ram.sv
// rtl/host_mem_responder_ram.sv - 1W/1R synchronous read-first word RAM
module host_mem_resp_ram #(
  parameter int WORDS = 4096,
  parameter int AW    = 12,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [WORDS];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  // array lookup feeding the output register; a same-cycle write is not visible yet
  always_comb begin
    rdata_d = mem[raddr];
  end

  // storage update; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/host_mem_responder.sv
// rtl/host_mem_responder.sv - host memory responder top; HOST_MEM_RESP_STATS_EN builds beat counters
module host_mem_responder
  import host_mem_resp_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter int          ADDR_WID  = 12,
  parameter int          DATA_WID  = 32,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          RD_LAT    = 2,
  parameter int          WR_LAT    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  host_mem_responder_if.slave bus,
  input  logic                done,
  output logic                done_seen,
  output logic                err,
  input  logic                bd_we,
  input  logic [ADDR_WID-1:0] bd_addr,
  input  logic [DATA_WID-1:0] bd_wdata,
  output logic [DATA_WID-1:0] bd_rdata,
  output logic [31:0]         rd_beats,
  output logic [31:0]         wr_beats
);
  localparam cnt_t        RD_LOAD = cnt_t'(RD_LAT);
  localparam cnt_t        WR_LOAD = cnt_t'(WR_LAT);
  localparam logic [63:0] WORDS64 = 64'(MEM_WORDS);

  logic [1:0]          rd_state_q, rd_state_d;
  cnt_t                rd_cnt_q, rd_cnt_d;
  logic [ADDR_WID-1:0] rd_idx_q, rd_idx_d;
  logic                rd_bad_q, rd_bad_d;
  logic                rd_port_q, rd_port_d;
  logic [DATA_WID-1:0] rd_hold_q, rd_hold_d;
  logic [DATA_WID-1:0] bd_hold_q, bd_hold_d;
  logic [1:0]          wr_state_q, wr_state_d;
  cnt_t                wr_cnt_q, wr_cnt_d;
  logic                err_q, err_d;
  logic                done_seen_q, done_seen_d;

  logic                rd_sample, rd_mem_cycle, wr_commit, both_idle;
  logic                rd_addr_bad, wr_addr_bad;
  logic [ADDR_WID-1:0] rd_addr_idx, wr_addr_idx;
  logic                ram_we;
  logic [ADDR_WID-1:0] ram_waddr, ram_raddr;
  logic [DATA_WID-1:0] ram_wdata, ram_rdata;
  logic [DATA_WID-1:0] read_data_w;
  logic                rd_pulse, wr_pulse;
  logic                unused_ok;

  assign unused_ok = ^{bus.read_size_output, bus.write_size};

  assign rd_addr_bad = addr_bad(bus.read_addr, BASE_ADDR, WORDS64);
  assign wr_addr_bad = addr_bad(bus.write_addr, BASE_ADDR, WORDS64);
  assign rd_addr_idx = ADDR_WID'(word_index(bus.read_addr, BASE_ADDR));
  assign wr_addr_idx = ADDR_WID'(word_index(bus.write_addr, BASE_ADDR));

  // read beat sequencing: sample address, count latency, pulse ready, wait for ack
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_idx_d   = rd_idx_q;
    rd_bad_d   = rd_bad_q;
    rd_sample  = 1'b0;
    case (rd_state_q)
      R_IDLE:  if (bus.read_enable) rd_sample = 1'b1;
      R_LAT: begin
        if (!bus.read_enable)        rd_state_d = R_IDLE;
        else if (rd_cnt_q == 4'd1)   rd_state_d = R_READY;
        else                         rd_cnt_d   = rd_cnt_q - 4'd1;
      end
      R_READY: rd_state_d = R_WAIT;
      R_WAIT: begin
        if (bus.finish_read)         rd_sample  = 1'b1;
        else if (!bus.read_enable)   rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    if (rd_sample) begin
      rd_state_d = R_LAT;
      rd_cnt_d   = RD_LOAD;
      rd_idx_d   = rd_addr_idx;
      rd_bad_d   = rd_addr_bad;
    end
  end

  // write beat sequencing: count latency, commit and pulse ready, wait for ack
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    case (wr_state_q)
      W_IDLE: begin
        if (bus.write_enable) begin
          wr_state_d = W_LAT;
          wr_cnt_d   = WR_LOAD;
        end
      end
      W_LAT: begin
        if (!bus.write_enable)       wr_state_d = W_IDLE;
        else if (wr_cnt_q == 4'd1)   wr_state_d = W_READY;
        else                         wr_cnt_d   = wr_cnt_q - 4'd1;
      end
      W_READY: wr_state_d = W_WAIT;
      W_WAIT: begin
        if (bus.finish_write) begin
          wr_state_d = W_LAT;
          wr_cnt_d   = WR_LOAD;
        end else if (!bus.write_enable) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // RAM port arbitration, data holding and sticky flags
  always_comb begin
    rd_mem_cycle = (rd_state_q == R_LAT) && (rd_cnt_q == 4'd1);
    wr_commit    = (wr_state_q == W_READY);
    both_idle    = (rd_state_q == R_IDLE) && (wr_state_q == W_IDLE);
    rd_pulse     = (rd_state_q == R_READY);
    wr_pulse     = wr_commit;

    ram_we    = wr_commit ? !wr_addr_bad : (bd_we && both_idle);
    ram_waddr = wr_commit ? wr_addr_idx : bd_addr;
    ram_wdata = wr_commit ? bus.write_data : bd_wdata;
    ram_raddr = rd_mem_cycle ? rd_idx_q : bd_addr;
    rd_port_d = rd_mem_cycle;

    read_data_w = rd_hold_q;
    if (rd_pulse) read_data_w = rd_bad_q ? DATA_WID'(BAD_DATA) : ram_rdata;
    rd_hold_d = read_data_w;

    bd_rdata  = rd_port_q ? bd_hold_q : ram_rdata;
    bd_hold_d = bd_rdata;

    err_d       = err_q | (rd_sample & rd_addr_bad) | (wr_commit & wr_addr_bad);
    done_seen_d = done_seen_q | done;
  end

  // state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q  <= R_IDLE;
      rd_cnt_q    <= '0;
      rd_idx_q    <= '0;
      rd_bad_q    <= 1'b0;
      rd_port_q   <= 1'b0;
      rd_hold_q   <= '0;
      bd_hold_q   <= '0;
      wr_state_q  <= W_IDLE;
      wr_cnt_q    <= '0;
      err_q       <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_idx_q    <= rd_idx_d;
      rd_bad_q    <= rd_bad_d;
      rd_port_q   <= rd_port_d;
      rd_hold_q   <= rd_hold_d;
      bd_hold_q   <= bd_hold_d;
      wr_state_q  <= wr_state_d;
      wr_cnt_q    <= wr_cnt_d;
      err_q       <= err_d;
      done_seen_q <= done_seen_d;
    end
  end

  host_mem_resp_ram #(
    .WORDS (MEM_WORDS),
    .AW    (ADDR_WID),
    .DW    (DATA_WID)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr   (ram_raddr),
    .rdata   (ram_rdata)
  );

  assign bus.read_ready  = {63'd0, rd_pulse};
  assign bus.write_ready = {63'd0, wr_pulse};
  assign bus.read_data   = read_data_w;
  assign err             = err_q;
  assign done_seen       = done_seen_q;

`ifdef HOST_MEM_RESP_STATS_EN
  logic [31:0] rd_beats_q, rd_beats_d;
  logic [31:0] wr_beats_q, wr_beats_d;

  // saturating per-pulse beat counters
  always_comb begin
    rd_beats_d = rd_beats_q;
    wr_beats_d = wr_beats_q;
    if (rd_pulse && (rd_beats_q != 32'hFFFF_FFFF)) rd_beats_d = rd_beats_q + 32'd1;
    if (wr_pulse && (wr_beats_q != 32'hFFFF_FFFF)) wr_beats_d = wr_beats_q + 32'd1;
  end

  // counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_beats_q <= '0;
      wr_beats_q <= '0;
    end else begin
      rd_beats_q <= rd_beats_d;
      wr_beats_q <= wr_beats_d;
    end
  end

  assign rd_beats = rd_beats_q;
  assign wr_beats = wr_beats_q;
`else
  assign rd_beats = 32'd0;
  assign wr_beats = 32'd0;
`endif

endmodule

// File: tb/tb_host_mem_responder.sv
// tb/tb_host_mem_responder.sv - directed self-checking bench for host_mem_responder
module tb_host_mem_responder;

  logic        clk;
  logic        reset_n;
  logic        done;
  logic        done_seen;
  logic        err;
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [31:0] bd_wdata;
  logic [31:0] bd_rdata;
  logic [31:0] rd_beats;
  logic [31:0] wr_beats;
  int          vectors;
  int          miscompares;
  int          n;

  host_mem_responder_if #(.DATA_WID(32)) bus ();

  host_mem_responder #(
    .MEM_WORDS (4096),
    .ADDR_WID  (12),
    .DATA_WID  (32),
    .BASE_ADDR (64'h0),
    .RD_LAT    (2),
    .WR_LAT    (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .done      (done),
    .done_seen (done_seen),
    .err       (err),
    .bd_we     (bd_we),
    .bd_addr   (bd_addr),
    .bd_wdata  (bd_wdata),
    .bd_rdata  (bd_rdata),
    .rd_beats  (rd_beats),
    .wr_beats  (wr_beats)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bus.read_ready[0] && cnt < 20);
  endtask

  task automatic wait_wr(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bus.write_ready[0] && cnt < 20);
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic bd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bd_addr = a;
    tick();
    chk(tag, bd_rdata, exp);
  endtask

  task automatic single_write(input logic [63:0] a, input logic [31:0] d);
    int c;
    bus.write_enable = 1'b1; bus.write_addr = a; bus.write_data = d;
    tick();
    wait_wr(c);
    chk("wr1_lat", c, 1);
    tick();
    bus.write_enable = 1'b0;
    tick();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0; done = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    bus.read_enable = 1'b0; bus.read_addr = '0; bus.read_size_output = 64'd4; bus.finish_read = 1'b0;
    bus.write_enable = 1'b0; bus.write_addr = '0; bus.write_data = '0; bus.write_size = 64'd4;
    bus.finish_write = 1'b0;
    repeat (2) tick();

    chk("rst_read_ready", bus.read_ready, 0);
    chk("rst_write_ready", bus.write_ready, 0);
    chk("rst_read_data", bus.read_data, 0);
    chk("rst_bd_rdata", bd_rdata, 0);
    chk("rst_done_seen", done_seen, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_beats", rd_beats, 0);
    chk("rst_wr_beats", wr_beats, 0);

    reset_n = 1'b1;
    tick();
    bd_write(12'd0, 32'd10);
    bd_write(12'd1, 32'd20);
    bd_write(12'd2, 32'd30);
    bd_write(12'd3, 32'd40);
    bd_write(12'd8, 32'h11);
    bd_write(12'd17, 32'h1717);

    // four-beat read burst from word 0
    bus.read_enable = 1'b1; bus.read_addr = 64'h0;
    tick();
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        bus.finish_read = 1'b1; bus.read_addr = 64'(b * 4);
        tick();
        bus.finish_read = 1'b0;
      end
      wait_rd(n);
      chk("rd_lat", n, 2);
      chk("rd_data", bus.read_data, 64'((b + 1) * 10));
      tick();
      chk("rd_pulse_width", bus.read_ready, 0);
      chk("rd_data_hold", bus.read_data, 64'((b + 1) * 10));
    end
    bus.read_enable = 1'b0;
    tick();
    chk("rd_err", err, 0);

    // three-beat write burst to byte 0x10; back-door write attempted while busy
    bus.write_enable = 1'b1; bus.write_addr = 64'h10; bus.write_data = 32'd7;
    tick();
    for (int b = 0; b < 3; b++) begin
      if (b > 0) begin
        bus.finish_write = 1'b1; bus.write_addr = 64'(16 + b * 4); bus.write_data = 32'(7 + b);
        tick();
        bus.finish_write = 1'b0;
      end
      wait_wr(n);
      chk("wr_lat", n, 1);
      tick();
      chk("wr_pulse_width", bus.write_ready, 0);
      if (b == 0) bd_write(12'd8, 32'h88);
    end
    bus.write_enable = 1'b0;
    tick();
`ifdef HOST_MEM_RESP_STATS_EN
    chk("stat_rd_beats", rd_beats, 4);
    chk("stat_wr_beats", wr_beats, 3);
`else
    chk("stat_rd_beats", rd_beats, 0);
    chk("stat_wr_beats", wr_beats, 0);
`endif
    bd_chk("bd_idx4", 12'd4, 32'd7);
    bd_chk("bd_idx5", 12'd5, 32'd8);
    bd_chk("bd_idx6", 12'd6, 32'd9);
    bd_chk("bd_busy_ignored", 12'd8, 32'h11);
    chk("wr_err", err, 0);

    // out-of-range and misaligned read, then write to same address
    bus.read_enable = 1'b1; bus.read_addr = 64'h4002;
    tick();
    wait_rd(n);
    chk("bad_rd_lat", n, 2);
    chk("bad_rd_data", bus.read_data, 32'hDEADBEEF);
    chk("bad_rd_err", err, 1);
    tick();
    bus.read_enable = 1'b0;
    tick();
    single_write(64'h4002, 32'h55);
    bd_chk("bad_wr_dropped", 12'd0, 32'd10);

    // last valid word
    single_write(64'h3FFC, 32'hA5A5_0001);
    bd_chk("last_word", 12'd4095, 32'hA5A5_0001);

    // abort a read in its latency phase
    bus.read_enable = 1'b1; bus.read_addr = 64'h0;
    tick();
    bus.read_enable = 1'b0;
    tick();
    chk("abort_no_ready", bus.read_ready, 0);
    bd_write(12'd7, 32'h77);
    chk("abort_no_ready2", bus.read_ready, 0);
    chk("abort_data_held", bus.read_data, 32'hDEADBEEF);
    bd_chk("abort_idle_bd", 12'd7, 32'h77);

    done = 1'b1;
    tick();
    done = 1'b0;
    chk("done_seen", done_seen, 1);

    // reset in the middle of a write burst
    bus.write_enable = 1'b1; bus.write_addr = 64'h40; bus.write_data = 32'h21;
    tick();
    wait_wr(n);
    chk("rst_burst_lat0", n, 1);
    tick();
    bus.finish_write = 1'b1; bus.write_addr = 64'h44; bus.write_data = 32'h22;
    tick();
    bus.finish_write = 1'b0;
    wait_wr(n);
    chk("rst_burst_lat1", n, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_write_ready", bus.write_ready, 0);
    chk("midrst_read_data", bus.read_data, 0);
    chk("midrst_err", err, 0);
    chk("midrst_done_seen", done_seen, 0);
    chk("midrst_bd_rdata", bd_rdata, 0);
    chk("midrst_rd_beats", rd_beats, 0);
    chk("midrst_wr_beats", wr_beats, 0);
    tick();
    reset_n = 1'b1;
    bus.write_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_no_ready", bus.write_ready, 0);
    end
    bd_chk("committed_kept", 12'd16, 32'h21);
    bd_chk("pending_dropped", 12'd17, 32'h1717);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/host_mem_responder.md
# host_mem_responder

Memory-side responder for the accelerator streaming read/write protocol. It serves word reads that the accelerator wrapper issues through `read_enable`/`read_addr`/`finish_read`, and accepts writes through `write_enable`/`write_addr`/`write_data`/`finish_write`. Requests are served from an internal word memory with programmable latency. It stands in for the host memory in simulation and FPGA self-test, and a back-door port lets the bench preload and dump contents.

## Interface

Parameters:
- `MEM_WORDS`, 4096: memory depth in 32-bit words.
- `ADDR_WID`, 12: word-index width; must equal log2(`MEM_WORDS`).
- `DATA_WID`, 32: data width.
- `BASE_ADDR`, 64'h0: byte address of word 0.
- `RD_LAT`, 2: cycles from request sample to `read_ready` pulse; legal range 1..15.
- `WR_LAT`, 1: cycles from request sample to `write_ready` pulse; legal range 1..15.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous active-low reset.
- `read_enable` in 1: read burst active.
- `read_addr` in 64: byte address of the current beat.
- `read_size_output` in 64: bytes per beat; ignored (always 4).
- `finish_read` in 1: pulse acknowledging a beat; `read_addr` already holds the next address.
- `read_ready` out 64: 0 or 1; a one-cycle pulse per beat.
- `read_data` out 32: beat data; held until the next beat.
- `write_enable` in 1: write burst active.
- `write_addr` in 64: byte address of the current beat.
- `write_data` in 32: beat data.
- `write_size` in 64: ignored.
- `finish_write` in 1: pulse; the next address and data are valid.
- `write_ready` out 64: 0 or 1; a one-cycle pulse per committed beat.
- `done` in 1: accelerator completion pulse.
- `done_seen` out 1: sticky; set by `done`.
- `err` out 1: sticky; set on an out-of-range or misaligned access.
- `bd_we` in 1, `bd_addr` in `ADDR_WID`, `bd_wdata` in 32, `bd_rdata` out 32: back-door port; `bd_rdata` is registered, with 1-cycle latency.
- `rd_beats` out 32, `wr_beats` out 32: statistics (see Configuration).

## Operation

- Address decode: idx = (addr − `BASE_ADDR`) >> 2. An address is invalid if addr < `BASE_ADDR`, idx ≥ `MEM_WORDS`, or addr[1:0] ≠ 0.
  - Invalid read returns 32'hDEADBEEF.
  - Invalid write is dropped.
  - Both set `err`.
- Read FSM states:
  - R_IDLE: on `read_enable`=1, sample `read_addr`, load the latency counter with `RD_LAT`, go to R_LAT.
  - R_LAT: count down; memory is read in the cycle the counter reaches 1, and the registered data lands in `read_data`; then go to R_READY.
  - R_READY: `read_ready`=1 for exactly one cycle, then go to R_WAIT.
  - R_WAIT: on `finish_read`=1, sample `read_addr` and reload the counter, go to R_LAT. Otherwise, on `read_enable`=0, go to R_IDLE. Otherwise stay.
- Write FSM, independent of the read FSM:
  - W_IDLE: on `write_enable`=1, load the counter with `WR_LAT`, go to W_LAT.
  - W_LAT: count down, then go to W_READY.
  - W_READY: sample `write_addr`/`write_data` and commit to memory in this cycle; `write_ready`=1 for one cycle; go to W_WAIT.
  - W_WAIT: same transitions as R_WAIT, using `finish_write`/`write_enable`.
- The responder never increments addresses itself; it always uses the sampled input address.
- Back-door writes are honored only while both FSMs are idle; otherwise they are ignored.

## Timing

- Reset state (async): both FSMs idle, all counters cleared. `read_ready`=0, `write_ready`=0, `read_data`=0, `bd_rdata`=0, `done_seen`=0, `err`=0, `rd_beats`=0, `wr_beats`=0. Memory contents are not reset.
- Read latency: request sampled in cycle 0 → `read_ready` high in cycle `RD_LAT`. After `finish_read` in cycle t → `read_ready` in cycle t+`RD_LAT`.
- Write latency: request sampled in cycle 0 → `write_ready` high in cycle `WR_LAT`.
- `read_ready` is never high in two consecutive cycles. This protects the initiator, which samples every cycle in which ready is high.
- Dropping `enable` in R_LAT/W_LAT aborts the beat: the FSM returns to idle without a ready pulse, and an aborted write does not commit.
- A read and a write to the same word in the same cycle are read-first: the read returns the old data.
- A reset asserted mid-burst drops any pending beat, and no ready pulse is produced afterwards.

## Configuration

- `HOST_MEM_RESP_STATS_EN` defined: `rd_beats`/`wr_beats` count each `read_ready`/`write_ready` pulse, saturating at 2^32−1, and clear on reset.
- Not defined: both outputs are tied to 0 and no counter logic is built.

## Structure

- Package `host_mem_resp_pkg`: read and write state encodings, `BAD_DATA` = 32'hDEADBEEF, latency-counter width (4 bits).
- Sub-module `host_mem_resp_ram`: 1W/1R synchronous RAM with read-first behaviour. The back-door write is muxed onto the write port, and the back-door read shares the read port whenever the read FSM is not in its memory-read cycle.

## Test plan

- Preload words 0..3 = 10,20,30,40 via back-door. Run a 4-beat read at `BASE_ADDR` with `RD_LAT`=2 → 4 single-cycle `read_ready` pulses at 2-cycle spacing from each `finish_read`, `read_data` = 10,20,30,40, `err`=0.
- Run a 3-beat write of 7,8,9 to byte 0x10 → `write_ready` pulses 3 times; back-door reads of idx 4,5,6 return 7,8,9.
- Read byte address 0x4002 → `read_data`=32'hDEADBEEF and `err`=1. A write to the same address leaves memory unchanged.
- Drop `read_enable` during R_LAT → no `read_ready` pulse; the FSM is idle the next cycle.
- Assert `reset_n`=0 mid-write burst → outputs clear immediately; words already committed retain their values.
- With `HOST_MEM_RESP_STATS_EN`: after the first two scenarios, `rd_beats`=4 and `wr_beats`=3. Without it, both read 0.
